// File: rtl/sram_burst_arbiter.sv
// rtl/sram_burst_arbiter.sv - round-robin arbiter sharing one SRAM burst port between N line requesters
module sram_burst_arbiter #(
   parameter int N       = 2,
   parameter int AW      = 32,
   parameter int DW      = 768,
   parameter int MW      = 96,
   parameter int TIMEOUT = 1024
) (
   input  logic            clkCPU,
   input  logic            rst_n,
   input  logic [N-1:0]    s_stb,
   input  logic [N-1:0]    s_we,
   input  logic [N*AW-1:0] s_addr,
   input  logic [N*DW-1:0] s_din,
   input  logic [N*MW-1:0] s_dm,
   output logic [N-1:0]    s_ack,
   output logic [N-1:0]    s_err,
   output logic [DW-1:0]   s_dout,
   output logic            m_stb,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_din,
   output logic [MW-1:0]   m_dm,
   input  logic            m_ack,
   input  logic [DW-1:0]   m_dout,
   output logic            busy,
   output logic [1:0]      grant
);

   localparam int CW = $clog2(TIMEOUT);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] wd_cnt;
   logic          err_q;
   logic          mask_q;

   // Requester vectors padded to 4 bits so a 2-bit index always fits
   logic [3:0]    stb4;
   logic [3:0]    we4;
   logic [3:0]    grant_oh;
   logic [3:0]    elig4;
   logic          pick_valid;
   logic [1:0]    pick_idx;
   logic [2:0]    cand;

   // Eligible set: live strobes minus the requester just served (stale strobe guard)
   always_comb begin
      stb4     = 4'(s_stb);
      we4      = 4'(s_we);
      grant_oh = 4'b0001 << grant;
      elig4    = stb4 & ~(mask_q ? grant_oh : 4'b0000);
   end

   // Round-robin pick: first eligible index after the last grant, wrapping at N
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = grant;
      cand       = 3'd0;
      for (int k = 1; k <= N; k++) begin
         cand = {1'b0, grant} + 3'(k);
         if (cand >= 3'(N)) begin
            cand = cand - 3'(N);
         end
         if (!pick_valid && elig4[cand[1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[1:0];
         end
      end
   end

   // Busy whenever a transaction (or the drain after a timeout) is outstanding
   always_comb begin
      busy = (state != S_IDLE);
   end

   // Transaction FSM: grant, single-cycle issue, wait with watchdog, respond, optional drain
   always_ff @(posedge clkCPU or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         wd_cnt <= '0;
         err_q  <= 1'b0;
         mask_q <= 1'b0;
         grant  <= 2'(N - 1);
         s_ack  <= '0;
         s_err  <= '0;
         s_dout <= '0;
         m_stb  <= 1'b0;
         m_we   <= 1'b0;
         m_addr <= '0;
         m_din  <= '0;
         m_dm   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               mask_q <= 1'b0;
               if (pick_valid) begin
                  grant  <= pick_idx;
                  m_we   <= we4[pick_idx];
                  m_addr <= s_addr[int'(pick_idx) * AW +: AW];
                  m_din  <= s_din[int'(pick_idx) * DW +: DW];
                  m_dm   <= s_dm[int'(pick_idx) * MW +: MW];
                  m_stb  <= 1'b1;
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               m_stb  <= 1'b0;
               wd_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               if (m_ack) begin
                  if (!m_we) begin
                     s_dout <= m_dout;
                  end
                  s_ack <= grant_oh[N-1:0];
                  err_q <= 1'b0;
                  state <= S_RESP;
               end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                  s_err <= grant_oh[N-1:0];
                  err_q <= 1'b1;
                  state <= S_RESP;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            S_RESP: begin
               s_ack <= '0;
               s_err <= '0;
               if (err_q) begin
                  state <= S_DRAIN;
               end else begin
                  mask_q <= 1'b1;
                  state  <= S_IDLE;
               end
            end
            S_DRAIN: begin
               // The late ack of the timed-out transaction is consumed without touching s_dout
               if (m_ack) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// tb/tb_sram_burst_arbiter.sv - scoreboard bench for sram_burst_arbiter
module tb_sram_burst_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 768;
   localparam int MW = 96;
   localparam int TO = 64;

   logic            clkCPU = 1'b0;
   logic            rst_n  = 1'b0;
   logic [N-1:0]    s_stb  = '0;
   logic [N-1:0]    s_we   = '0;
   logic [N*AW-1:0] s_addr = '0;
   logic [N*DW-1:0] s_din  = '0;
   logic [N*MW-1:0] s_dm   = '0;
   logic [N-1:0]    s_ack;
   logic [N-1:0]    s_err;
   logic [DW-1:0]   s_dout;
   logic            m_stb;
   logic            m_we;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_din;
   logic [MW-1:0]   m_dm;
   logic            m_ack  = 1'b0;
   logic [DW-1:0]   m_dout = '0;
   logic            busy;
   logic [1:0]      grant;

   always #5 clkCPU = ~clkCPU;

   sram_burst_arbiter #(.N(N), .AW(AW), .DW(DW), .MW(MW), .TIMEOUT(TO)) dut (
      .clkCPU(clkCPU), .rst_n(rst_n),
      .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_din(s_din), .s_dm(s_dm),
      .s_ack(s_ack), .s_err(s_err), .s_dout(s_dout),
      .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dm(m_dm),
      .m_ack(m_ack), .m_dout(m_dout), .busy(busy), .grant(grant)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [MW-1:0] dm;
      int            req;
   } mtx_t;

   typedef struct {
      int            req;
      bit            err;
      logic [DW-1:0] dout;
   } rsp_t;

   mtx_t          mq[$];
   rsp_t          rq[$];
   mtx_t          me;
   rsp_t          re;
   int            checks = 0;
   int            errors = 0;
   int            stb_count = 0;
   bit            prev_stb = 0;
   logic [DW-1:0] exp_dout = '0;
   int            last_g = N - 1;
   int            hold[N];

   // Wrapper model
   int            ack_cnt = -1;
   int            ack_delay = 5;
   bit            no_ack = 0;
   bit            late_ack = 0;
   logic [DW-1:0] rd_data = '0;

   always @(negedge clkCPU) begin
      m_ack  = 1'b0;
      m_dout = ~rd_data;
      if (!rst_n) begin
         ack_cnt = -1;
      end else begin
         if (ack_cnt > 0) ack_cnt--;
         if (ack_cnt == 0) begin
            m_ack   = 1'b1;
            m_dout  = rd_data;
            ack_cnt = -1;
         end
         if (late_ack) begin
            m_ack    = 1'b1;
            m_dout   = {(DW/16){16'hDEAD}};
            late_ack = 0;
         end
         if (m_stb && !no_ack) ack_cnt = ack_delay;
      end
   end

   // Scoreboard monitor
   always @(negedge clkCPU) begin
      if (!rst_n) begin
         prev_stb = 0;
      end else begin
         if (m_stb) begin
            stb_count++;
            checks++;
            if (prev_stb) begin
               errors++;
               $display("FAIL m_stb_width: m_stb high two cycles running, want single-cycle pulse");
            end
            checks++;
            if (mq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_m_stb: got m_stb addr=%h grant=%0d, want none", m_addr, grant);
            end else begin
               me = mq.pop_front();
               if ({m_we, m_addr, m_din, m_dm, grant} !== {me.we, me.addr, me.din, me.dm, 2'(me.req)}) begin
                  errors++;
                  $display("FAIL m_txn: got we=%0b addr=%h grant=%0d dm=%h din_lo=%h, want we=%0b addr=%h grant=%0d dm=%h din_lo=%h",
                           m_we, m_addr, grant, m_dm, m_din[63:0], me.we, me.addr, me.req, me.dm, me.din[63:0]);
               end
            end
         end
         prev_stb = m_stb;
         if (s_ack != '0 || s_err != '0) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rsp: got s_ack=%b s_err=%b, want none", s_ack, s_err);
            end else begin
               re = rq.pop_front();
               if (s_ack !== (re.err ? N'(0) : N'(1 << re.req)) ||
                   s_err !== (re.err ? N'(1 << re.req) : N'(0)) ||
                   s_dout !== re.dout) begin
                  errors++;
                  $display("FAIL rsp: got s_ack=%b s_err=%b dout_lo=%h, want req=%0d err=%0b dout_lo=%h",
                           s_ack, s_err, s_dout[63:0], re.req, re.err, re.dout[63:0]);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(negedge clkCPU);
      #1;
   endtask

   task automatic set_req(input int r, input logic we, input logic [AW-1:0] addr);
      s_we[r]            = we;
      s_addr[r*AW +: AW] = addr;
      s_din[r*DW +: DW]  = {24{$urandom()}};
      s_dm[r*MW +: MW]   = {3{$urandom()}};
   endtask

   // Push expected wrapper transaction and response in service order
   task automatic expect_txn(input int r, input bit will_err);
      mtx_t m;
      rsp_t p;
      m.we   = s_we[r];
      m.addr = s_addr[r*AW +: AW];
      m.din  = s_din[r*DW +: DW];
      m.dm   = s_dm[r*MW +: MW];
      m.req  = r;
      mq.push_back(m);
      p.req  = r;
      p.err  = will_err;
      p.dout = (will_err || s_we[r]) ? exp_dout : rd_data;
      if (!will_err && !s_we[r]) exp_dout = rd_data;
      rq.push_back(p);
      last_g = r;
   endtask

   task automatic reset_assert();
      rst_n    = 1'b0;
      s_stb    = '0;
      mq.delete();
      rq.delete();
      exp_dout = '0;
      last_g   = N - 1;
      no_ack   = 0;
      #1;
   endtask

   task automatic reset_release();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic run_until(input int nresp, input int budget, input bit late_drop, output bit ok);
      int seen = 0;
      int cyc = 0;
      logic [N-1:0] drop_next = '0;
      ok = 0;
      while (cyc < budget && !ok) begin
         step();
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (s_ack[i] || s_err[i]) begin
               seen++;
               hold[i]--;
               if (hold[i] <= 0) begin
                  if (late_drop) drop_next[i] = 1'b1;
                  else s_stb[i] = 1'b0;
               end
            end
         end
         if (seen >= nresp) ok = 1;
      end
      if (drop_next != '0) begin
         step();
         s_stb = s_stb & ~drop_next;
      end
   endtask

   task automatic test_reset();
      reset_assert();
      step();
      checks++;
      if ({s_ack, s_err, m_stb, m_we, busy, grant} !== {N'(0), N'(0), 1'b0, 1'b0, 1'b0, 2'(N-1)}) begin
         errors++;
         $display("FAIL reset_ctrl: got ack=%b err=%b m_stb=%b m_we=%b busy=%b grant=%0d, want zeros grant=%0d",
                  s_ack, s_err, m_stb, m_we, busy, grant, N-1);
      end
      checks++;
      if (m_addr !== '0 || m_din !== '0 || m_dm !== '0 || s_dout !== '0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h dm=%h din_lo=%h dout_lo=%h, want 0", m_addr, m_dm, m_din[63:0], s_dout[63:0]);
      end
      reset_release();
   endtask

   task automatic test_single_read();
      int k;
      int base;
      ack_delay = 20;
      rd_data   = {96{8'hA5}};
      set_req(0, 1'b0, 32'h100);
      s_stb[0] = 1'b1;
      expect_txn(0, 0);
      base = stb_count;
      step();
      checks++;
      if (m_stb !== 1'b1 || m_addr !== 32'h100) begin
         errors++;
         $display("FAIL read_issue_latency: got m_stb=%b addr=%h, want 1 and 100", m_stb, m_addr);
      end
      k = 0;
      while (k < 100 && s_ack[0] !== 1'b1) begin
         step();
         k++;
      end
      checks++;
      if (k != 21) begin
         errors++;
         $display("FAIL read_ack_latency: got %0d cycles, want 21", k);
      end
      // Requester keeps its strobe one cycle past the ack; no duplicate may issue
      step();
      s_stb[0] = 1'b0;
      repeat (4) step();
      checks++;
      if (stb_count - base != 1 || busy !== 1'b0 || s_dout !== {96{8'hA5}}) begin
         errors++;
         $display("FAIL read_single: got pulses=%0d busy=%b dout_lo=%h, want 1 0 a5a5..", stb_count - base, busy, s_dout[63:0]);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      int base;
      reset_assert();
      reset_release();
      ack_delay = 7;
      rd_data   = {96{8'h3C}};
      set_req(0, 1'b0, 32'h200);
      set_req(1, 1'b1, 32'h300);
      expect_txn(0, 0);
      expect_txn(1, 0);
      hold[0] = 1;
      hold[1] = 1;
      base = stb_count;
      s_stb = 2'b11;
      run_until(2, 200, 0, ok);
      repeat (4) step();
      checks++;
      if (!ok || stb_count - base != 2) begin
         errors++;
         $display("FAIL simultaneous: got done=%0b pulses=%0d, want 1 2", ok, stb_count - base);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int base;
      ack_delay = 3;
      rd_data   = {96{8'h96}};
      set_req(0, 1'b0, 32'h1000);
      set_req(1, 1'b0, 32'h2000);
      for (int t = 0; t < 6; t++) begin
         expect_txn((last_g + 1) % N, 0);
      end
      hold[0] = 3;
      hold[1] = 3;
      base = stb_count;
      s_stb = 2'b11;
      run_until(6, 400, 0, ok);
      repeat (4) step();
      checks++;
      if (!ok || stb_count - base != 6 || mq.size() != 0 || rq.size() != 0) begin
         errors++;
         $display("FAIL round_robin: got done=%0b pulses=%0d left=%0d/%0d, want 1 6 0/0",
                  ok, stb_count - base, mq.size(), rq.size());
      end
   endtask

   task automatic test_timeout();
      int k;
      int base;
      bit ok;
      no_ack = 1;
      set_req(0, 1'b0, 32'h400);
      s_stb[0] = 1'b1;
      expect_txn(0, 1);
      step();
      k = 0;
      while (k < 200 && s_err[0] !== 1'b1) begin
         step();
         k++;
      end
      checks++;
      if (k != TO + 1 || s_ack !== '0) begin
         errors++;
         $display("FAIL timeout_err: got %0d cycles s_ack=%b, want %0d and 0", k, s_ack, TO + 1);
      end
      s_stb[0] = 1'b0;
      set_req(1, 1'b1, 32'h500);
      s_stb[1] = 1'b1;
      expect_txn(1, 0);
      base = stb_count;
      repeat (10) step();
      checks++;
      if (busy !== 1'b1 || stb_count != base) begin
         errors++;
         $display("FAIL drain_hold: got busy=%b pulses=%0d, want 1 0", busy, stb_count - base);
      end
      no_ack    = 0;
      ack_delay = 4;
      rd_data   = {96{8'h77}};
      late_ack  = 1;
      hold[1]   = 1;
      run_until(1, 100, 0, ok);
      repeat (3) step();
      checks++;
      if (!ok || stb_count - base != 1 || s_dout !== exp_dout) begin
         errors++;
         $display("FAIL after_drain: got done=%0b pulses=%0d dout_lo=%h, want 1 1 %h",
                  ok, stb_count - base, s_dout[63:0], exp_dout[63:0]);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      ack_delay = 30;
      rd_data   = {96{8'hE1}};
      set_req(0, 1'b0, 32'h600);
      s_stb[0] = 1'b1;
      expect_txn(0, 0);
      step();
      repeat (5) step();
      reset_assert();
      checks++;
      if ({s_ack, s_err, m_stb, m_we, busy, grant} !== {N'(0), N'(0), 1'b0, 1'b0, 1'b0, 2'(N-1)} ||
          m_addr !== '0 || m_din !== '0 || m_dm !== '0 || s_dout !== '0) begin
         errors++;
         $display("FAIL reset_mid: got ack=%b err=%b m_stb=%b busy=%b grant=%0d addr=%h dout_lo=%h, want reset values",
                  s_ack, s_err, m_stb, busy, grant, m_addr, s_dout[63:0]);
      end
      base = stb_count;
      reset_release();
      repeat (40) step();
      checks++;
      if (stb_count != base || s_dout !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_quiet: got pulses=%0d dout_lo=%h busy=%b, want 0 0 0", stb_count - base, s_dout[63:0], busy);
      end
   endtask

   task automatic test_write_then_read();
      bit ok;
      ack_delay = 3;
      rd_data   = {96{8'h5A}};
      set_req(1, 1'b1, 32'h700);
      expect_txn(1, 0);
      hold[1] = 1;
      s_stb[1] = 1'b1;
      run_until(1, 100, 0, ok);
      checks++;
      if (!ok || s_dout !== '0) begin
         errors++;
         $display("FAIL write_keeps_dout: got done=%0b dout_lo=%h, want 1 0", ok, s_dout[63:0]);
      end
      rd_data = {96{8'hC3}};
      set_req(1, 1'b0, 32'h780);
      expect_txn(1, 0);
      hold[1] = 1;
      s_stb[1] = 1'b1;
      run_until(1, 100, 0, ok);
      repeat (3) step();
      checks++;
      if (!ok || s_dout !== {96{8'hC3}} || mq.size() != 0 || rq.size() != 0) begin
         errors++;
         $display("FAIL read_updates_dout: got done=%0b dout_lo=%h left=%0d/%0d, want 1 c3c3.. 0/0",
                  ok, s_dout[63:0], mq.size(), rq.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      test_write_then_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
